control_sequencer: RTL

- Hardwired control unit that drives every control input of ALU_System. This is the same control bundle the ALU_System bench applies from test vectors.
- Fetches a 16-bit instruction from memory into IR, low byte first, then high byte.
- Decodes the instruction and issues one execute cycle. POP needs two execute cycles.
- Sits directly above ALU_System and closes the loop through IROut and ALUOutFlag.

---
 rtl/control_sequencer.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Hardwired control unit for ALU_System: fetches a 16-bit instruction low byte first,
// then decodes and executes it. Define CU_STACK_EN to enable PUSH (0xE) and POP (0xF).
module control_sequencer #(
  parameter logic [3:0] ALU_PASSA = 4'd0,
  parameter logic [3:0] ALU_ADD   = 4'd4,
  parameter logic [3:0] ALU_SUB   = 4'd6,
  parameter logic [3:0] ALU_AND   = 4'd7,
  parameter logic [3:0] ALU_OR    = 4'd8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  ALUOutFlag,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RSel,
  output logic [3:0]  RF_TSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        Halted,
  output logic [2:0]  State
);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_FETCH_L = 3'd1,
    S_FETCH_H = 3'd2,
    S_EXEC    = 3'd3,
    S_EXEC2   = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'h0;
  localparam logic [3:0] OP_LDM  = 4'h1;
  localparam logic [3:0] OP_STM  = 4'h2;
  localparam logic [3:0] OP_LDAR = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_INC  = 4'h8;
  localparam logic [3:0] OP_DEC  = 4'h9;
  localparam logic [3:0] OP_BRA  = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_HLT  = 4'hD;
  localparam logic [3:0] OP_PUSH = 4'hE;
  localparam logic [3:0] OP_POP  = 4'hF;

  localparam logic [1:0] FN_CLR  = 2'b00;
  localparam logic [1:0] FN_LOAD = 2'b01;
  localparam logic [1:0] FN_DEC  = 2'b10;
  localparam logic [1:0] FN_INC  = 2'b11;

  localparam logic [1:0] ARF_PC = 2'b00;
  localparam logic [1:0] ARF_AR = 2'b01;
  localparam logic [1:0] ARF_SP = 2'b10;

  localparam logic [3:0] REG_PC = 4'b1000;
  localparam logic [3:0] REG_AR = 4'b0100;
  localparam logic [3:0] REG_SP = 4'b0010;

  localparam logic [1:0] MUX_ALU = 2'b00;
  localparam logic [1:0] MUX_MEM = 2'b01;
  localparam logic [1:0] MUX_IMM = 2'b10;

  state_t state_q, state_d;

  logic [3:0] opcode;
  logic [1:0] rx, rs;
  logic [3:0] rx_onehot;
  logic       z_flag;
  logic [4:0] unused_bits;

  assign opcode    = IROut[15:12];
  assign rx        = IROut[9:8];
  assign rs        = IROut[1:0];
  assign rx_onehot = 4'b1000 >> rx;
  assign z_flag    = ALUOutFlag[3];
  assign unused_bits = {ALUOutFlag[2:0], IROut[11:10]};

  assign State = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:    state_d = S_FETCH_L;
      S_FETCH_L: state_d = S_FETCH_H;
      S_FETCH_H: state_d = S_EXEC;
      S_EXEC: begin
        if (opcode == OP_HLT) state_d = S_HALT;
`ifdef CU_STACK_EN
        else if (opcode == OP_POP) state_d = S_EXEC2;
`endif
        else state_d = S_FETCH_L;
      end
      S_EXEC2:   state_d = S_FETCH_L;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_INIT;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  // Outputs are a pure decode of the current state and instruction so that a
  // reset drops every write enable in the same instant it lowers State.
  always_comb begin
    RF_OutASel  = 3'd0;
    RF_OutBSel  = 3'd0;
    RF_FunSel   = FN_CLR;
    RF_RSel     = 4'b0000;
    RF_TSel     = 4'b0000;
    ALU_FunSel  = ALU_PASSA;
    ARF_OutCSel = ARF_PC;
    ARF_OutDSel = ARF_PC;
    ARF_FunSel  = FN_CLR;
    ARF_RegSel  = 4'b0000;
    IR_LH       = 1'b0;
    IR_Enable   = 1'b0;
    IR_Funsel   = FN_CLR;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = MUX_ALU;
    MuxBSel     = MUX_ALU;
    MuxCSel     = 1'b0;
    Halted      = 1'b0;

    case (state_q)
      S_INIT: begin
        ARF_RegSel = REG_PC;
        ARF_FunSel = FN_CLR;
      end
      S_FETCH_L, S_FETCH_H: begin
        Mem_CS      = 1'b0;
        ARF_OutDSel = ARF_PC;
        IR_Enable   = 1'b1;
        IR_Funsel   = FN_LOAD;
        IR_LH       = (state_q == S_FETCH_H);
        ARF_RegSel  = REG_PC;
        ARF_FunSel  = FN_INC;
      end
      S_EXEC: begin
        case (opcode)
          OP_LDI: begin
            RF_RSel   = rx_onehot;
            RF_FunSel = FN_LOAD;
            MuxASel   = MUX_IMM;
          end
          OP_LDM: begin
            ARF_OutDSel = ARF_AR;
            Mem_CS      = 1'b0;
            MuxASel     = MUX_MEM;
            RF_RSel     = rx_onehot;
            RF_FunSel   = FN_LOAD;
          end
          OP_STM: begin
            RF_OutASel  = {1'b0, rx};
            MuxCSel     = 1'b0;
            ALU_FunSel  = ALU_PASSA;
            ARF_OutDSel = ARF_AR;
            Mem_CS      = 1'b0;
            Mem_WR      = 1'b1;
          end
          OP_LDAR: begin
            ARF_RegSel = REG_AR;
            ARF_FunSel = FN_LOAD;
            MuxBSel    = MUX_IMM;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            RF_OutASel = {1'b0, rx};
            RF_OutBSel = {1'b0, rs};
            MuxCSel    = 1'b0;
            MuxASel    = MUX_ALU;
            RF_RSel    = rx_onehot;
            RF_FunSel  = FN_LOAD;
            case (opcode)
              OP_ADD:  ALU_FunSel = ALU_ADD;
              OP_SUB:  ALU_FunSel = ALU_SUB;
              OP_AND:  ALU_FunSel = ALU_AND;
              default: ALU_FunSel = ALU_OR;
            endcase
          end
          OP_INC: begin
            RF_RSel   = rx_onehot;
            RF_FunSel = FN_INC;
          end
          OP_DEC: begin
            RF_RSel   = rx_onehot;
            RF_FunSel = FN_DEC;
          end
          OP_BRA, OP_BNE, OP_BEQ: begin
            // Z reflects the most recent ALU instruction.
            if ((opcode == OP_BRA) ||
                (opcode == OP_BNE && !z_flag) ||
                (opcode == OP_BEQ &&  z_flag)) begin
              ARF_RegSel = REG_PC;
              ARF_FunSel = FN_LOAD;
              MuxBSel    = MUX_IMM;
            end
          end
`ifdef CU_STACK_EN
          OP_PUSH: begin
            // Memory sees the pre-decrement SP; the decrement lands on the same edge.
            RF_OutASel  = {1'b0, rx};
            MuxCSel     = 1'b0;
            ALU_FunSel  = ALU_PASSA;
            ARF_OutDSel = ARF_SP;
            Mem_CS      = 1'b0;
            Mem_WR      = 1'b1;
            ARF_RegSel  = REG_SP;
            ARF_FunSel  = FN_DEC;
          end
          OP_POP: begin
            ARF_RegSel = REG_SP;
            ARF_FunSel = FN_INC;
          end
`else
          OP_PUSH, OP_POP: ;
`endif
          default: ;
        endcase
      end
      S_EXEC2: begin
`ifdef CU_STACK_EN
        ARF_OutDSel = ARF_SP;
        Mem_CS      = 1'b0;
        MuxASel     = MUX_MEM;
        RF_RSel     = rx_onehot;
        RF_FunSel   = FN_LOAD;
`endif
      end
      S_HALT: Halted = 1'b1;
      default: ;
    endcase
  end

endmodule
